// File: rtl/exec_unit_mc_if.sv
// Execute-stage bus: upstream op handshake, downstream result handshake, busy status.
interface exec_unit_mc_if #(
  parameter int XLEN   = 32,
  parameter int PC_W   = 10,
  parameter int IMM_W  = 20,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_class;
  logic [3:0]        in_alu_op;
  logic [2:0]        in_funct3;
  logic              in_use_imm;
  logic [XLEN-1:0]   in_op1;
  logic [XLEN-1:0]   in_op2;
  logic [IMM_W-1:0]  in_imm;
  logic [PC_W-1:0]   in_pc;
  logic [REG_AW-1:0] in_rd;
  logic              out_valid;
  logic              out_ready;
  logic [REG_AW-1:0] out_rd;
  logic [XLEN-1:0]   out_result;
  logic [XLEN-1:0]   out_mem_addr;
  logic [XLEN-1:0]   out_store_data;
  logic              out_is_load;
  logic              out_is_store;
  logic              out_branch;
  logic [PC_W-1:0]   out_target;
  logic              busy;

  modport master (
    output in_valid, in_class, in_alu_op, in_funct3, in_use_imm, in_op1, in_op2,
           in_imm, in_pc, in_rd, out_ready,
    input  in_ready, out_valid, out_rd, out_result, out_mem_addr, out_store_data,
           out_is_load, out_is_store, out_branch, out_target, busy
  );

  modport slave (
    input  in_valid, in_class, in_alu_op, in_funct3, in_use_imm, in_op1, in_op2,
           in_imm, in_pc, in_rd, out_ready,
    output in_ready, out_valid, out_rd, out_result, out_mem_addr, out_store_data,
           out_is_load, out_is_store, out_branch, out_target, busy
  );
endinterface

// File: rtl/exec_unit_mc.sv
// Execute stage: single-cycle ALU/branch/jump/mem/LUI path plus an iterative
// RV32M shift-add multiplier and restoring divider sharing one datapath.
module exec_unit_mc #(
  parameter int XLEN   = 32,
  parameter int PC_W   = 10,
  parameter int IMM_W  = 20,
  parameter int REG_AW = 5
) (
  input logic          clk,
  input logic          rst,
  exec_unit_mc_if.slave bus
);
  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN + 1);

  localparam logic [2:0] C_ALU = 3'd0, C_BR = 3'd1, C_JMP = 3'd2, C_LD = 3'd3,
                         C_ST  = 3'd4, C_LUI = 3'd5, C_MD = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   result;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   store_data;
    logic              is_load;
    logic              is_store;
    logic              branch;
    logic [PC_W-1:0]   target;
  } out_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   acc_q, acc_d, lo_q, lo_d, bm_q, bm_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d, dz_q, dz_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  out_t              out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              rdy_q;

  logic            out_free, accept;
  logic [XLEN-1:0] imm_sx, b_op, alu_res, ea;
  logic [SHW-1:0]  shamt;
  logic            br_take;
  logic [PC_W-1:0] tgt, pc_inc;
  out_t            sc;

  assign out_free     = !out_valid_q || bus.out_ready;
  assign bus.in_ready = rdy_q && (state_q == S_IDLE) && out_free;
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.busy     = (state_q != S_IDLE);

  assign imm_sx = {{(XLEN-12){bus.in_imm[11]}}, bus.in_imm[11:0]};
  assign b_op   = bus.in_use_imm ? imm_sx : bus.in_op2;
  assign shamt  = b_op[SHW-1:0];
  assign ea     = bus.in_op1 + imm_sx;
  assign tgt    = bus.in_pc + bus.in_imm[PC_W-1:0];
  assign pc_inc = bus.in_pc + PC_W'(1);

  always_comb begin
    alu_res = '0;
    case (bus.in_alu_op)
      4'd0: alu_res = bus.in_op1 + b_op;
      4'd1: alu_res = bus.in_op1 - b_op;
      4'd2: alu_res = bus.in_op1 << shamt;
      4'd3: alu_res = XLEN'($signed(bus.in_op1) < $signed(b_op));
      4'd4: alu_res = XLEN'(bus.in_op1 < b_op);
      4'd5: alu_res = bus.in_op1 ^ b_op;
      4'd6: alu_res = bus.in_op1 >> shamt;
      4'd7: alu_res = $signed(bus.in_op1) >>> shamt;
      4'd8: alu_res = bus.in_op1 | b_op;
      4'd9: alu_res = bus.in_op1 & b_op;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    br_take = 1'b0;
    case (bus.in_funct3)
      3'd0: br_take = (bus.in_op1 == bus.in_op2);
      3'd1: br_take = (bus.in_op1 != bus.in_op2);
      3'd4: br_take = ($signed(bus.in_op1) <  $signed(bus.in_op2));
      3'd5: br_take = ($signed(bus.in_op1) >= $signed(bus.in_op2));
      3'd6: br_take = (bus.in_op1 <  bus.in_op2);
      3'd7: br_take = (bus.in_op1 >= bus.in_op2);
      default: br_take = 1'b0;
    endcase
  end

  always_comb begin
    sc    = '0;
    sc.rd = bus.in_rd;
    case (bus.in_class)
      C_ALU: sc.result = alu_res;
      C_BR: begin
        sc.branch = br_take;
        sc.target = tgt;
      end
      C_JMP: begin
        sc.branch = 1'b1;
        sc.target = tgt;
        sc.result = XLEN'(pc_inc);
      end
      C_LD: begin
        sc.is_load  = 1'b1;
        sc.mem_addr = ea;
      end
      C_ST: begin
        sc.is_store = 1'b1;
        sc.mem_addr = ea;
        case (bus.in_funct3[1:0])
          2'd0:    sc.store_data = XLEN'(bus.in_op2[7:0]);
          2'd1:    sc.store_data = XLEN'(bus.in_op2[15:0]);
          default: sc.store_data = bus.in_op2;
        endcase
      end
      C_LUI:   sc.result = XLEN'({bus.in_imm, 12'b0});
      default: ;
    endcase
  end

  // Operands are reduced to magnitudes up front; neg records the sign to restore at FIN.
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [2:0]      f3;
  assign f3    = bus.in_funct3;
  assign a_sgn = f3[2] ? !f3[0] : (f3 == 3'd1 || f3 == 3'd2);
  assign b_sgn = f3[2] ? !f3[0] : (f3 == 3'd1);
  assign a_neg = a_sgn && bus.in_op1[XLEN-1];
  assign b_neg = b_sgn && bus.in_op2[XLEN-1];
  assign a_mag = a_neg ? -bus.in_op1 : bus.in_op1;
  assign b_mag = b_neg ? -bus.in_op2 : bus.in_op2;

  logic [XLEN:0]     mul_sum, div_sh, div_tr;
  logic [2*XLEN-1:0] prod, prod_fx;
  logic [XLEN-1:0]   q_fx, r_fx, md_res;
  assign mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, bm_q} : '0);
  assign div_sh  = {acc_q, lo_q[XLEN-1]};
  assign div_tr  = div_sh - {1'b0, bm_q};
  assign prod    = {acc_q, lo_q};
  assign prod_fx = neg_q ? -prod : prod;
  // Divide by zero: the restoring loop leaves rem = |dividend|, so only the quotient is forced.
  assign q_fx    = dz_q ? '1 : (neg_q ? -lo_q : lo_q);
  assign r_fx    = neg_q ? -acc_q : acc_q;
  assign md_res  = f3_q[2] ? (f3_q[1] ? r_fx : q_fx)
                           : ((f3_q == 3'd0) ? prod_fx[XLEN-1:0] : prod_fx[2*XLEN-1:XLEN]);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    lo_d        = lo_q;
    bm_d        = bm_q;
    f3_d        = f3_q;
    neg_d       = neg_q;
    dz_d        = dz_q;
    rd_d        = rd_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && bus.in_class == C_MD) begin
          state_d = S_RUN;
          cnt_d   = CW'(XLEN);
          acc_d   = '0;
          lo_d    = f3[2] ? a_mag : b_mag;
          bm_d    = f3[2] ? b_mag : a_mag;
          f3_d    = f3;
          neg_d   = (f3[2] && f3[1]) ? a_neg : (a_neg ^ b_neg);
          dz_d    = (bus.in_op2 == '0);
          rd_d    = bus.in_rd;
        end else if (accept) begin
          out_d       = sc;
          out_valid_d = 1'b1;
        end
      end
      S_RUN: begin
        if (f3_q[2]) begin
          acc_d = div_tr[XLEN] ? div_sh[XLEN-1:0] : div_tr[XLEN-1:0];
          lo_d  = {lo_q[XLEN-2:0], !div_tr[XLEN]};
        end else begin
          acc_d = mul_sum[XLEN:1];
          lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIN;
      end
      S_FIN: begin
        if (out_free) begin
          out_d        = '0;
          out_d.rd     = rd_q;
          out_d.result = md_res;
          out_valid_d  = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      lo_q        <= '0;
      bm_q        <= '0;
      f3_q        <= '0;
      neg_q       <= 1'b0;
      dz_q        <= 1'b0;
      rd_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      lo_q        <= lo_d;
      bm_q        <= bm_d;
      f3_q        <= f3_d;
      neg_q       <= neg_d;
      dz_q        <= dz_d;
      rd_q        <= rd_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      rdy_q       <= 1'b1;
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.out_rd         = out_q.rd;
  assign bus.out_result     = out_q.result;
  assign bus.out_mem_addr   = out_q.mem_addr;
  assign bus.out_store_data = out_q.store_data;
  assign bus.out_is_load    = out_q.is_load;
  assign bus.out_is_store   = out_q.is_store;
  assign bus.out_branch     = out_q.branch;
  assign bus.out_target     = out_q.target;
endmodule

// File: tb/tb_exec_unit_mc.sv
// Directed bench for exec_unit_mc: single-cycle classes, handshake, mul/div, reset abort.
module tb_exec_unit_mc;
  localparam int XLEN = 32, PC_W = 10, IMM_W = 20, REG_AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exec_unit_mc_if #(.XLEN(XLEN), .PC_W(PC_W), .IMM_W(IMM_W), .REG_AW(REG_AW)) bus();
  exec_unit_mc #(.XLEN(XLEN), .PC_W(PC_W), .IMM_W(IMM_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  localparam int NMD = 13;
  logic [2:0]  md_f3  [NMD] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
  logic [31:0] md_a   [NMD] = '{32'd6, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'h80000000, 32'h80000000, 32'd5, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                32'hFFFFFFF9, 32'hFFFFFFF9};
  logic [31:0] md_b   [NMD] = '{32'd7, 32'd5, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd2, 32'd2, 32'd0, 32'd0};
  logic [31:0] md_exp [NMD] = '{32'd42, 32'hFFFFFFF1, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE,
                                32'h80000000, 32'd0, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                32'hFFFFFFFF, 32'hFFFFFFF9};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] cls, input logic [3:0] aop, input logic [2:0] f3,
                        input logic ui, input logic [31:0] a, input logic [31:0] b,
                        input logic [19:0] imm, input logic [9:0] pc, input logic [4:0] rd);
    bus.in_class   = cls;
    bus.in_alu_op  = aop;
    bus.in_funct3  = f3;
    bus.in_use_imm = ui;
    bus.in_op1     = a;
    bus.in_op2     = b;
    bus.in_imm     = imm;
    bus.in_pc      = pc;
    bus.in_rd      = rd;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_op(3'd7, 4'd0, 3'd0, 1'b0, 32'd0, 32'd0, 20'd0, 10'd0, 5'd0);
    #2;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    total++; if (bus.out_result !== 32'd0 || bus.out_branch !== 1'b0 || bus.out_target !== 10'd0)
      begin bad++; $display("FAIL rst_outs got=%h/%b/%h exp=0/0/0", bus.out_result, bus.out_branch, bus.out_target); end
    step();
    rst = 1'b0;
    step();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    set_op(3'd0, 4'd0, 3'd0, 1'b0, 32'd7, 32'hFFFFFFFD, 20'd0, 10'd0, 5'd1);
    bus.in_valid = 1'b1;
    step();
    total++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd4 || bus.out_rd !== 5'd1)
      begin bad++; $display("FAIL b2b_add got=%b/%h/%0d exp=1/4/1", bus.out_valid, bus.out_result, bus.out_rd); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", bus.in_ready); end
    set_op(3'd0, 4'd1, 3'd0, 1'b0, 32'd7, 32'hFFFFFFFD, 20'd0, 10'd0, 5'd2);
    step();
    total++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd10 || bus.out_rd !== 5'd2)
      begin bad++; $display("FAIL b2b_sub got=%b/%h/%0d exp=1/a/2", bus.out_valid, bus.out_result, bus.out_rd); end
    bus.in_valid = 1'b0;
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_branch();
    set_op(3'd1, 4'd0, 3'd4, 1'b0, 32'hFFFFFFFF, 32'd1, 20'h00020, 10'h3F0, 5'd0);
    bus.in_valid = 1'b1;
    step();
    total++; if (bus.out_branch !== 1'b1 || bus.out_target !== 10'h010 || bus.out_result !== 32'd0)
      begin bad++; $display("FAIL blt got=%b/%h/%h exp=1/010/0", bus.out_branch, bus.out_target, bus.out_result); end
    bus.in_funct3 = 3'd6;
    step();
    total++; if (bus.out_branch !== 1'b0 || bus.out_valid !== 1'b1)
      begin bad++; $display("FAIL bltu got=%b/%b exp=0/1", bus.out_branch, bus.out_valid); end
    bus.in_funct3 = 3'd2;
    bus.in_op2    = 32'hFFFFFFFF;
    step();
    total++; if (bus.out_branch !== 1'b0) begin bad++; $display("FAIL br_f3_2 got=%b exp=0", bus.out_branch); end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_misc();
    bus.in_valid = 1'b1;
    set_op(3'd0, 4'd7, 3'd0, 1'b0, 32'hFFFFFFF0, 32'h00000022, 20'd0, 10'd0, 5'd3);
    step();
    total++; if (bus.out_result !== 32'hFFFFFFFC) begin bad++; $display("FAIL sra got=%h exp=fffffffc", bus.out_result); end
    set_op(3'd0, 4'd4, 3'd0, 1'b1, 32'd1, 32'd0, 20'h00FFF, 10'd0, 5'd3);
    step();
    total++; if (bus.out_result !== 32'd1) begin bad++; $display("FAIL sltu_imm got=%h exp=1", bus.out_result); end
    set_op(3'd0, 4'd12, 3'd0, 1'b0, 32'd5, 32'd6, 20'd0, 10'd0, 5'd3);
    step();
    total++; if (bus.out_result !== 32'd0) begin bad++; $display("FAIL alu_undef got=%h exp=0", bus.out_result); end
    set_op(3'd5, 4'd0, 3'd0, 1'b0, 32'd0, 32'd0, 20'h12345, 10'd0, 5'd4);
    step();
    total++; if (bus.out_result !== 32'h12345000) begin bad++; $display("FAIL lui got=%h exp=12345000", bus.out_result); end
    set_op(3'd2, 4'd0, 3'd0, 1'b0, 32'd0, 32'd0, 20'h00010, 10'h3FF, 5'd1);
    step();
    total++; if (bus.out_branch !== 1'b1 || bus.out_target !== 10'h00F || bus.out_result !== 32'd0)
      begin bad++; $display("FAIL jump got=%b/%h/%h exp=1/00f/0", bus.out_branch, bus.out_target, bus.out_result); end
    set_op(3'd2, 4'd0, 3'd0, 1'b0, 32'd0, 32'd0, 20'h00010, 10'h005, 5'd1);
    step();
    total++; if (bus.out_target !== 10'h015 || bus.out_result !== 32'd6)
      begin bad++; $display("FAIL jump_link got=%h/%h exp=015/6", bus.out_target, bus.out_result); end
    set_op(3'd3, 4'd0, 3'd2, 1'b0, 32'h200, 32'd0, 20'h00FFC, 10'd0, 5'd7);
    step();
    total++; if (bus.out_is_load !== 1'b1 || bus.out_is_store !== 1'b0 || bus.out_mem_addr !== 32'h1FC || bus.out_result !== 32'd0)
      begin bad++; $display("FAIL load got=%b/%b/%h/%h exp=1/0/1fc/0", bus.out_is_load, bus.out_is_store, bus.out_mem_addr, bus.out_result); end
    set_op(3'd4, 4'd0, 3'd1, 1'b0, 32'h300, 32'h12345678, 20'h00008, 10'd0, 5'd0);
    step();
    total++; if (bus.out_is_store !== 1'b1 || bus.out_mem_addr !== 32'h308 || bus.out_store_data !== 32'h5678)
      begin bad++; $display("FAIL sh got=%b/%h/%h exp=1/308/5678", bus.out_is_store, bus.out_mem_addr, bus.out_store_data); end
    set_op(3'd7, 4'd0, 3'd0, 1'b0, 32'h5, 32'h6, 20'h00001, 10'd1, 5'd9);
    step();
    total++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd0 || bus.out_is_load !== 1'b0 || bus.out_is_store !== 1'b0 || bus.out_branch !== 1'b0 || bus.out_rd !== 5'd9)
      begin bad++; $display("FAIL class7 got=%b/%h/%b%b%b/%0d exp=1/0/000/9", bus.out_valid, bus.out_result, bus.out_is_load, bus.out_is_store, bus.out_branch, bus.out_rd); end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_muldiv();
    int cyc;
    for (int i = 0; i < NMD; i++) begin
      set_op(3'd6, 4'd0, md_f3[i], 1'b0, md_a[i], md_b[i], 20'd0, 10'd0, 5'd11);
      bus.in_valid = 1'b1;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL md%0d_ready_pre got=%b exp=1", i, bus.in_ready); end
      step();
      bus.in_valid = 1'b0;
      total++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0)
        begin bad++; $display("FAIL md%0d_busy got=%b/%b exp=1/0", i, bus.busy, bus.in_ready); end
      cyc = 0;
      while (bus.out_valid !== 1'b1 && cyc < 100) begin
        step();
        cyc++;
      end
      total++; if (cyc !== XLEN + 1) begin bad++; $display("FAIL md%0d_latency got=%0d exp=%0d", i, cyc, XLEN + 1); end
      total++; if (bus.out_result !== md_exp[i] || bus.out_rd !== 5'd11)
        begin bad++; $display("FAIL md%0d_result f3=%0d got=%h/%0d exp=%h/11", i, md_f3[i], bus.out_result, bus.out_rd, md_exp[i]); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL md%0d_busy_done got=%b exp=0", i, bus.busy); end
    end
    step();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    set_op(3'd0, 4'd0, 3'd0, 1'b0, 32'd5, 32'd6, 20'd0, 10'd0, 5'd4);
    bus.in_valid = 1'b1;
    step();
    set_op(3'd4, 4'd0, 3'd0, 1'b0, 32'h100, 32'h12345678, 20'h00004, 10'd0, 5'd0);
    for (int k = 0; k < 5; k++) begin
      total++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd11 || bus.out_rd !== 5'd4 || bus.out_is_store !== 1'b0)
        begin bad++; $display("FAIL bp_hold%0d got=%b/%h/%0d/%b exp=1/b/4/0", k, bus.out_valid, bus.out_result, bus.out_rd, bus.out_is_store); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready%0d got=%b exp=0", k, bus.in_ready); end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.out_is_store !== 1'b1 || bus.out_mem_addr !== 32'h104 || bus.out_store_data !== 32'h78)
      begin bad++; $display("FAIL bp_sw got=%b/%b/%h/%h exp=1/1/104/78", bus.out_valid, bus.out_is_store, bus.out_mem_addr, bus.out_store_data); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_rst_midrun();
    int seen;
    set_op(3'd6, 4'd0, 3'd0, 1'b0, 32'd6, 32'd7, 20'd0, 10'd0, 5'd5);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (10) step();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mr_busy_pre got=%b exp=1", bus.busy); end
    rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
      begin bad++; $display("FAIL mr_abort got=%b/%b exp=0/0", bus.out_valid, bus.busy); end
    step();
    rst = 1'b0;
    step();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mr_ready got=%b exp=1", bus.in_ready); end
    seen = 0;
    repeat (40) begin
      step();
      if (bus.out_valid === 1'b1 || bus.busy === 1'b1) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL mr_stale got=%0d exp=0", seen); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_branch();
    test_misc();
    test_muldiv();
    test_backpressure();
    test_rst_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
